key_pulse_conditioner: RTL and testbench
========================================

# key_pulse_conditioner

Conditions one raw DE-board pushbutton into a clean debounced level, a single-cycle press pulse with optional hold-to-repeat, and a single-cycle release pulse. It sits directly upstream of the processor's input logic and drives the stepping-clock (CLKb) and peek (PeeKb) key inputs. Auto-repeat lets the operator single-step the processor by holding the clock key.

## Interface
- DEBOUNCE_CYCLES, 1_000_000: consecutive stable samples required to accept a press or release (20 ms at 50 MHz); must be ≥ 2.
- REPEAT_DELAY, 25_000_000: held cycles after the accepted press before the first repeat pulse (500 ms).
- REPEAT_PERIOD, 5_000_000: cycles between subsequent repeat pulses (100 ms).
- REPEAT_EN, 1: 1 enables auto-repeat; 0 means one pulse per press.
- CNT_W, 25: counter width; must satisfy 2^CNT_W > max(DEBOUNCE_CYCLES, REPEAT_DELAY, REPEAT_PERIOD).

- CLK50M  input  1  50 MHz system clock; the block has one clock.
- Clear_n  input  1  asynchronous, active-low reset.
- A_noisy  input  1  raw pushbutton, asynchronous, active-low (0 = pressed).
- A  output  1  debounced level, 1 = pressed.
- A_pulse  output  1  one-cycle pulse on the accepted press and on each repeat.
- A_release  output  1  one-cycle pulse on the accepted release.

## Operation
- Synchronizer: two flops on A_noisy, reset to 1 (unpressed). The FSM uses only the second flop, inverted, as `p` (1 = pressed).
- Counter `cnt` (CNT_W bits) is cleared on every state change and counts up in the states listed below. It never exceeds the active terminal value, so it cannot wrap.
- FSM states: IDLE, PRESS_DB, HELD, REPEAT, REL_DB.
  - IDLE: when p=1, go to PRESS_DB.
  - PRESS_DB: when p=0, return to IDLE with no pulse. When cnt==DEBOUNCE_CYCLES-1 and p=1, go to HELD and pulse A_pulse. Otherwise increment cnt.
  - HELD: when p=0, go to REL_DB. When REPEAT_EN=1 and cnt==REPEAT_DELAY-1, go to REPEAT and pulse A_pulse. Otherwise increment cnt. With REPEAT_EN=0, cnt holds at 0.
  - REPEAT: when p=0, go to REL_DB. When cnt==REPEAT_PERIOD-1, pulse A_pulse and clear cnt. Otherwise increment cnt.
  - REL_DB: when p=1, return to HELD with cnt=0 (bounce absorbed, no pulse, repeat delay restarts). When cnt==DEBOUNCE_CYCLES-1 and p=0, go to IDLE and pulse A_release. Otherwise increment cnt.
- A is registered: it goes to 1 on entry to HELD, stays 1 through HELD, REPEAT and REL_DB, and goes to 0 on entry to IDLE.
- A_pulse and A_release are registered and are never high in the same cycle.
- If p drops and a repeat terminal count falls in the same cycle, p=0 wins: the block goes to REL_DB with no pulse.

## Timing
- Reset values: A=0, A_pulse=0, A_release=0, state=IDLE, cnt=0, synchronizer=1.
- Clear_n asserted at any time, including mid-debounce or mid-repeat, forces all of the above immediately. No pulse is emitted on reset entry or exit.
- Deassertion of Clear_n is assumed synchronized externally. After reset, a key that is already held must pass a full debounce before any pulse.
- Press latency: let A_noisy go low and stay low before edge k. Then the synchronizer output is valid at edge k+1, PRESS_DB is entered at edge k+2, and A and A_pulse rise at edge k+2+DEBOUNCE_CYCLES. A_pulse is high for exactly one cycle.
- First repeat pulse: REPEAT_DELAY cycles after the press pulse. Later repeat pulses: every REPEAT_PERIOD cycles.
- Release latency: A falls and A_release pulses DEBOUNCE_CYCLES+2 edges after A_noisy returns high and stays high.
- Any glitch shorter than DEBOUNCE_CYCLES samples produces no output change.

## Test plan
Sim parameters: DEBOUNCE_CYCLES=4, REPEAT_DELAY=10, REPEAT_PERIOD=3.

1. Clean press: A_noisy low for 8 cycles, then high -> A_pulse high for exactly 1 cycle, 6 edges after the low edge; A=1; A_release pulses 6 edges after the rising edge; A=0.
2. Bounce: A_noisy toggles every 2 cycles for 20 cycles, then stays high -> A, A_pulse and A_release stay 0 throughout.
3. Auto-repeat: key held 30 cycles -> press pulse, then repeat pulses 10, 13, 16, 19 and 22 cycles after it (6 pulses total), then one A_release after release.
4. REPEAT_EN=0, key held 40 cycles -> exactly one A_pulse and one A_release.
5. Release bounce: while in REPEAT, a 2-cycle high glitch -> no A_release, A stays 1, the next repeat pulse comes REPEAT_DELAY cycles after return to HELD.
6. Reset mid-operation: Clear_n pulsed low during PRESS_DB (cnt=2) with the key still held -> outputs 0 immediately; after release of reset, press pulse at full latency (6 edges from the first sampled low).

Source files
------------

// File: rtl/key_pulse_conditioner_if.sv
// Pushbutton bundle: raw active-low key in, conditioned level and pulses out.
interface key_pulse_conditioner_if;
   logic A_noisy;
   logic A;
   logic A_pulse;
   logic A_release;

   modport master (
      output A_noisy,
      input  A,
      input  A_pulse,
      input  A_release
   );

   modport slave (
      input  A_noisy,
      output A,
      output A_pulse,
      output A_release
   );
endinterface

// File: rtl/key_pulse_conditioner.sv
// Pushbutton conditioner: sync, debounce, press/release pulses, hold-to-repeat.
module key_pulse_conditioner #(
   parameter int unsigned DEBOUNCE_CYCLES = 1_000_000,
   parameter int unsigned REPEAT_DELAY    = 25_000_000,
   parameter int unsigned REPEAT_PERIOD   = 5_000_000,
   parameter bit          REPEAT_EN       = 1'b1,
   parameter int unsigned CNT_W           = 25
) (
   input  logic                    CLK50M,
   input  logic                    Clear_n,
   key_pulse_conditioner_if.slave  key
);

   localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [CNT_W-1:0] RD_LAST = CNT_W'(REPEAT_DELAY - 1);
   localparam logic [CNT_W-1:0] RP_LAST = CNT_W'(REPEAT_PERIOD - 1);
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

   typedef enum logic [2:0] {
      IDLE,
      PRESS_DB,
      HELD,
      REPEAT,
      REL_DB
   } state_e;

   state_e           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             sync1_q, sync1_d;
   logic             sync2_q, sync2_d;
   logic             a_q, a_d;
   logic             pulse_q, pulse_d;
   logic             rel_q, rel_d;
   logic             p;

   always_ff @(posedge CLK50M or negedge Clear_n) begin
      if (!Clear_n) begin
         sync1_q <= 1'b1;
         sync2_q <= 1'b1;
         state_q <= IDLE;
         cnt_q   <= '0;
         a_q     <= 1'b0;
         pulse_q <= 1'b0;
         rel_q   <= 1'b0;
      end else begin
         sync1_q <= sync1_d;
         sync2_q <= sync2_d;
         state_q <= state_d;
         cnt_q   <= cnt_d;
         a_q     <= a_d;
         pulse_q <= pulse_d;
         rel_q   <= rel_d;
      end
   end

   always_comb begin
      sync1_d = key.A_noisy;
      sync2_d = sync1_q;
      p       = ~sync2_q;
      state_d = state_q;
      cnt_d   = cnt_q + CNT_ONE;
      pulse_d = 1'b0;
      rel_d   = 1'b0;

      unique case (state_q)
         IDLE: begin
            cnt_d = '0;
            if (p) state_d = PRESS_DB;
         end
         PRESS_DB: begin
            if (!p) begin
               state_d = IDLE;
               cnt_d   = '0;
            end else if (cnt_q == DB_LAST) begin
               state_d = HELD;
               cnt_d   = '0;
               pulse_d = 1'b1;
            end
         end
         HELD: begin
            if (!p) begin
               state_d = REL_DB;
               cnt_d   = '0;
            end else if (!REPEAT_EN) begin
               cnt_d = '0;
            end else if (cnt_q == RD_LAST) begin
               state_d = REPEAT;
               cnt_d   = '0;
               pulse_d = 1'b1;
            end
         end
         // a key drop outranks a coincident repeat terminal count
         REPEAT: begin
            if (!p) begin
               state_d = REL_DB;
               cnt_d   = '0;
            end else if (cnt_q == RP_LAST) begin
               cnt_d   = '0;
               pulse_d = 1'b1;
            end
         end
         REL_DB: begin
            if (p) begin
               state_d = HELD;
               cnt_d   = '0;
            end else if (cnt_q == DB_LAST) begin
               state_d = IDLE;
               cnt_d   = '0;
               rel_d   = 1'b1;
            end
         end
         default: begin
            state_d = IDLE;
            cnt_d   = '0;
         end
      endcase

      a_d = (state_d == HELD) || (state_d == REPEAT) ||
            (state_d == REL_DB);
   end

   assign key.A         = a_q;
   assign key.A_pulse   = pulse_q;
   assign key.A_release = rel_q;

endmodule

// File: tb/tb_key_pulse_conditioner.sv
// Directed bench: two conditioners (repeat on / off) with short timing.
module tb_key_pulse_conditioner;

   logic clk;
   logic clear_n;
   int   edge_n;
   int   n_assert;
   int   n_fail;
   int   e0;
   int   r_edge;
   int   ex[$];

   int   rp[$];
   int   rr[$];
   int   np[$];
   int   nr[$];
   int   ra_cnt;
   int   both_cnt;

   key_pulse_conditioner_if kr ();
   key_pulse_conditioner_if kn ();

   key_pulse_conditioner #(
      .DEBOUNCE_CYCLES(4),
      .REPEAT_DELAY(10),
      .REPEAT_PERIOD(3),
      .REPEAT_EN(1'b1),
      .CNT_W(8)
   ) u_rep (
      .CLK50M(clk),
      .Clear_n(clear_n),
      .key(kr)
   );

   key_pulse_conditioner #(
      .DEBOUNCE_CYCLES(4),
      .REPEAT_DELAY(10),
      .REPEAT_PERIOD(3),
      .REPEAT_EN(1'b0),
      .CNT_W(8)
   ) u_norep (
      .CLK50M(clk),
      .Clear_n(clear_n),
      .key(kn)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (kr.A_pulse === 1'b1) rp.push_back(edge_n);
      if (kr.A_release === 1'b1) rr.push_back(edge_n);
      if (kn.A_pulse === 1'b1) np.push_back(edge_n);
      if (kn.A_release === 1'b1) nr.push_back(edge_n);
      if (kr.A === 1'b1) ra_cnt++;
      if ((kr.A_pulse && kr.A_release) || (kn.A_pulse && kn.A_release))
         both_cnt++;
   end

   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk);
         edge_n++;
         #1;
      end
   endtask

   task automatic clr_logs();
      rp.delete();
      rr.delete();
      np.delete();
      nr.delete();
      ra_cnt = 0;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic chk_seq(input string tag, input int q[$],
                          input int exq[$], input int base);
      chk({tag, "_count"}, q.size(), exq.size());
      for (int i = 0; i < exq.size(); i++) begin
         if (i < q.size())
            chk($sformatf("%s[%0d]", tag, i), q[i] - base, exq[i]);
         else
            chk($sformatf("%s[%0d]", tag, i), -1, exq[i]);
      end
   endtask

   initial begin
      n_assert   = 0;
      n_fail     = 0;
      edge_n     = 0;
      both_cnt   = 0;
      ra_cnt     = 0;
      clear_n    = 1'b0;
      kr.A_noisy = 1'b1;
      kn.A_noisy = 1'b1;

      step(2);
      chk("rst_r_a", kr.A, 0);
      chk("rst_r_pulse", kr.A_pulse, 0);
      chk("rst_r_rel", kr.A_release, 0);
      chk("rst_n_a", kn.A, 0);
      chk("rst_n_pulse", kn.A_pulse, 0);
      chk("rst_n_rel", kn.A_release, 0);
      clear_n = 1'b1;
      step(3);

      // clean press and release
      clr_logs();
      e0 = edge_n;
      kr.A_noisy = 1'b0;
      step(6);
      chk("s1_a_early", kr.A, 0);
      chk("s1_pulse_early", kr.A_pulse, 0);
      step(1);
      chk("s1_pulse", kr.A_pulse, 1);
      chk("s1_a_rise", kr.A, 1);
      step(1);
      chk("s1_pulse_width", kr.A_pulse, 0);
      kr.A_noisy = 1'b1;
      step(6);
      chk("s1_a_hold", kr.A, 1);
      chk("s1_rel_early", kr.A_release, 0);
      step(1);
      chk("s1_rel", kr.A_release, 1);
      chk("s1_a_fall", kr.A, 0);
      step(1);
      chk("s1_rel_width", kr.A_release, 0);
      chk("s1_npulse", rp.size(), 1);
      chk("s1_nrel", rr.size(), 1);
      step(3);

      // bounce shorter than the debounce window
      clr_logs();
      for (int i = 0; i < 10; i++) begin
         kr.A_noisy = (i % 2 == 0) ? 1'b0 : 1'b1;
         step(2);
      end
      kr.A_noisy = 1'b1;
      step(10);
      chk("s2_a_high", ra_cnt, 0);
      chk("s2_npulse", rp.size(), 0);
      chk("s2_nrel", rr.size(), 0);
      step(3);

      // auto-repeat, release lands on a repeat terminal count
      clr_logs();
      e0 = edge_n;
      kr.A_noisy = 1'b0;
      step(29);
      kr.A_noisy = 1'b1;
      step(10);
      ex = '{7, 17, 20, 23, 26, 29};
      chk_seq("s3_pulse", rp, ex, e0);
      ex = '{36};
      chk_seq("s3_rel", rr, ex, e0);
      step(3);

      // repeat disabled
      clr_logs();
      e0 = edge_n;
      kn.A_noisy = 1'b0;
      step(40);
      kn.A_noisy = 1'b1;
      step(10);
      ex = '{7};
      chk_seq("s4_pulse", np, ex, e0);
      ex = '{47};
      chk_seq("s4_rel", nr, ex, e0);
      step(3);

      // release glitch while repeating
      clr_logs();
      e0 = edge_n;
      kr.A_noisy = 1'b0;
      step(20);
      kr.A_noisy = 1'b1;
      step(2);
      kr.A_noisy = 1'b0;
      step(2);
      chk("s5_a_in_reldb", kr.A, 1);
      step(2);
      chk("s5_a_reheld", kr.A, 1);
      chk("s5_no_rel", rr.size(), 0);
      step(10);
      kr.A_noisy = 1'b1;
      step(10);
      ex = '{7, 17, 20, 35, 38};
      chk_seq("s5_pulse", rp, ex, e0);
      ex = '{43};
      chk_seq("s5_rel", rr, ex, e0);
      step(3);

      // reset mid-debounce (rep) and mid-hold (norep)
      clr_logs();
      e0 = edge_n;
      kn.A_noisy = 1'b0;
      step(4);
      kr.A_noisy = 1'b0;
      step(5);
      chk("s6_n_held", kn.A, 1);
      #2;
      clear_n = 1'b0;
      #1;
      chk("s6_rst_r_a", kr.A, 0);
      chk("s6_rst_r_pulse", kr.A_pulse, 0);
      chk("s6_rst_r_rel", kr.A_release, 0);
      chk("s6_rst_n_a", kn.A, 0);
      step(2);
      r_edge = edge_n;
      clear_n = 1'b1;
      step(6);
      chk("s6_r_pulse_early", kr.A_pulse, 0);
      chk("s6_r_a_early", kr.A, 0);
      step(1);
      chk("s6_r_pulse", kr.A_pulse, 1);
      chk("s6_n_pulse", kn.A_pulse, 1);
      chk("s6_r_a", kr.A, 1);
      kr.A_noisy = 1'b1;
      kn.A_noisy = 1'b1;
      step(10);
      ex = '{7};
      chk_seq("s6_r_pulses", rp, ex, r_edge);
      chk("s6_n_pulses", np.size(), 2);
      chk("s6_no_rel_on_reset", nr.size(), 1);
      chk("no_overlap", both_cnt, 0);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_assert, n_fail);
      $finish;
   end

endmodule
